// File: rtl/clock_step_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_step_ctrl_pkg
// Shared definitions for the CPU clock-step controller: FSM state encoding
// and the default synchroniser depth for the divided-clock input.
// -----------------------------------------------------------------------------
package clock_step_ctrl_pkg;

   // Default number of synchroniser flops ahead of the edge detector.
   localparam int unsigned SYNC_STAGES_DEF = 2;

   // Width of the FSM state register.
   localparam int unsigned STATE_W = 2;

   // Run/halt/single-step controller states.
   typedef enum logic [STATE_W-1:0] {
      ST_HALT = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10
   } state_e;

endpackage : clock_step_ctrl_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Multi-flop synchroniser followed by a delay flop and a rising-edge detector.
// The input is treated as asynchronous data.
//
// Ports:
//   clk   in  system clock
//   res   in  synchronous active-high reset, clears all flops
//   d     in  asynchronous input level
//   q     out synchronised level (last synchroniser stage)
//   rise  out one-cycle pulse when q goes 0->1 (q & ~delayed q)
// -----------------------------------------------------------------------------
module sync_edge_det #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic res,
   input  logic d,
   output logic q,
   output logic rise
);

   logic [STAGES-1:0] sync;
   logic              dly;

   // Synchroniser chain plus one delay flop for edge detection.
   always_ff @(posedge clk) begin
      if (res) begin
         sync <= '0;
         dly  <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         dly  <= sync[STAGES-1];
      end
   end

   assign q    = sync[STAGES-1];
   assign rise = sync[STAGES-1] & ~dly;

endmodule : sync_edge_det

// File: rtl/clock_step_ctrl.sv
// -----------------------------------------------------------------------------
// clock_step_ctrl
// Consumer side of the CPU clock divider. Synchronises the divided clock,
// turns each rising edge into a one-cycle CPU clock enable gated by a
// run/halt/single-step FSM, and measures the divided period in clk cycles.
//
// Ports:
//   clk           in  system clock
//   res           in  synchronous active-high reset
//   tick_in       in  divided clock, asynchronous, treated as data
//   bypass        in  static; 1 = every clk cycle is a tick
//   run           in  level; 1 = free-run, 0 = halt
//   step          in  level; each 0->1 requests one CPU step
//   cpu_en        out one-cycle CPU clock enable
//   running       out 1 while the FSM is in RUN
//   step_done     out one-cycle pulse with the cpu_en of a single step
//   period        out last measured tick period in clk cycles, saturating
//   period_valid  out period holds a real measurement
// -----------------------------------------------------------------------------
module clock_step_ctrl
   import clock_step_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int unsigned PERIOD_W    = 16
) (
   input  logic                clk,
   input  logic                res,
   input  logic                tick_in,
   input  logic                bypass,
   input  logic                run,
   input  logic                step,
   output logic                cpu_en,
   output logic                running,
   output logic                step_done,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid
);

   localparam logic [PERIOD_W-1:0] COUNT_MAX = '1;

   state_e              state;
   logic                tick_level_unused;
   logic                sync_rise;
   logic                rise;
   logic                step_q;
   logic                step_rise;
   logic [PERIOD_W-1:0] count;
   logic                seen;

   // Synchronise and edge-detect the divided clock.
   sync_edge_det #(
      .STAGES (SYNC_STAGES)
   ) u_tick_sync (
      .clk  (clk),
      .res  (res),
      .d    (tick_in),
      .q    (tick_level_unused),
      .rise (sync_rise)
   );

   // In bypass mode every cycle is a tick; the period counter still uses sync_rise.
   assign rise      = bypass | sync_rise;
   assign step_rise = step & ~step_q;

   // Run/halt/single-step controller with registered outputs.
   always_ff @(posedge clk) begin
      if (res) begin
         state     <= ST_HALT;
         cpu_en    <= 1'b0;
         running   <= 1'b0;
         step_done <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         step_q    <= step;
         cpu_en    <= 1'b0;
         step_done <= 1'b0;
         unique case (state)
            ST_HALT: begin
               // run has priority; a coincident step request is discarded
               if (run) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end else if (step_rise) begin
                  state <= ST_STEP;
               end
            end
            ST_RUN: begin
               // a tick in the cycle run drops is still delivered
               cpu_en <= rise;
               if (!run) begin
                  state   <= ST_HALT;
                  running <= 1'b0;
               end
            end
            ST_STEP: begin
               if (rise) begin
                  cpu_en    <= 1'b1;
                  step_done <= 1'b1;
                  state     <= ST_HALT;
               end
            end
            default: begin
               state   <= ST_HALT;
               running <= 1'b0;
            end
         endcase
      end
   end

   // Period measurement on the synchronised tick; the first edge only arms it.
   always_ff @(posedge clk) begin
      if (res) begin
         count        <= '0;
         seen         <= 1'b0;
         period       <= '0;
         period_valid <= 1'b0;
      end else if (sync_rise) begin
         count <= PERIOD_W'(1);
         if (seen) begin
            period       <= count;
            period_valid <= 1'b1;
         end else begin
            seen <= 1'b1;
         end
      end else if (count != COUNT_MAX) begin
         count <= count + PERIOD_W'(1);
      end
   end

endmodule : clock_step_ctrl

// File: tb/tb_clock_step_ctrl.sv
module tb_clock_step_ctrl;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        tick_in = 1'b0;
   logic        bypass = 1'b0;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic        cpu_en;
   logic        running;
   logic        step_done;
   logic [15:0] period;
   logic        period_valid;

   logic        tick_sat = 1'b0;
   logic        cpu_en_s;
   logic        running_s;
   logic        step_done_s;
   logic [3:0]  period_s;
   logic        period_valid_s;

   logic        tick_en = 1'b0;
   int          ph = 7;
   int          ph_s = 39;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        sd;
      logic [15:0] per;
      logic        val;
   } exp_t;

   exp_t exp_q[$];

   clock_step_ctrl #(.SYNC_STAGES(2), .PERIOD_W(16)) dut (
      .clk(clk), .res(res), .tick_in(tick_in), .bypass(bypass), .run(run),
      .step(step), .cpu_en(cpu_en), .running(running), .step_done(step_done),
      .period(period), .period_valid(period_valid)
   );

   clock_step_ctrl #(.SYNC_STAGES(2), .PERIOD_W(4)) dut_sat (
      .clk(clk), .res(res), .tick_in(tick_sat), .bypass(1'b0), .run(1'b0),
      .step(1'b0), .cpu_en(cpu_en_s), .running(running_s), .step_done(step_done_s),
      .period(period_s), .period_valid(period_valid_s)
   );

   always #5 clk = ~clk;

   // Tick generators: main period 8 (4/4), toggling every cycle during initial reset;
   // saturation instance period 40 (20/20).
   always begin
      @(posedge clk);
      #1;
      if (tick_en) begin
         ph = (ph + 1) % 8;
         tick_in = (ph < 4);
      end else if (res) begin
         tick_in = ~tick_in;
      end else begin
         tick_in = 1'b0;
      end
      if (!res) begin
         ph_s = (ph_s + 1) % 40;
         tick_sat = (ph_s < 20);
      end
   end

   // Scoreboard monitor: every cpu_en pulse must match the next expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (step_done && !cpu_en) begin
         checks++;
         errors++;
         $display("FAIL step_done_alone t=%0t: step_done=1 cpu_en=0, required cpu_en=1", $time);
      end
      if (cpu_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_cpu_en t=%0t: got cpu_en=1, required no pulse", $time);
         end else begin
            e = exp_q.pop_front();
            if (step_done !== e.sd || period !== e.per || period_valid !== e.val) begin
               errors++;
               $display("FAIL pulse t=%0t: got sd=%0b period=%0d valid=%0b, required sd=%0b period=%0d valid=%0b",
                        $time, step_done, period, period_valid, e.sd, e.per, e.val);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s t=%0t: got %0d, required %0d", name, $time, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input logic sd, input int n);
      exp_t e;
      e.sd  = sd;
      e.per = 16'd8;
      e.val = 1'b1;
      repeat (n) exp_q.push_back(e);
   endtask

   // Returns at 2 time units after the posedge at which tick_in rose.
   task automatic wait_rise();
      logic prev;
      bit   found;
      prev  = tick_in;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk);
         #2;
         if (tick_in && !prev) found = 1'b1;
         prev = tick_in;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_rise t=%0t: no tick_in rise within 20 cycles", $time);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset for 3 cycles with tick_in toggling.
      cyc(3);
      chk("rst_cpu_en", 32'(cpu_en), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_step_done", 32'(step_done), 0);
      chk("rst_period", 32'(period), 0);
      chk("rst_period_valid", 32'(period_valid), 0);
      res = 1'b0;
      tick_en = 1'b1;
      cyc(30);

      // Free run: pulses at 3, 11, 19, 27 edges after the tick; run drops before 27.
      wait_rise();
      run = 1'b1;
      push(1'b0, 4);
      cyc(2);
      chk("lat_edge2", 32'(cpu_en), 0);
      cyc(1);
      chk("lat_edge3", 32'(cpu_en), 1);
      chk("run_running", 32'(running), 1);
      cyc(23);
      run = 1'b0;
      cyc(1);
      chk("drop_rise_honoured", 32'(cpu_en), 1);
      chk("drop_running", 32'(running), 0);
      cyc(20);

      // Single step with step held high afterwards.
      wait_rise();
      step = 1'b1;
      push(1'b1, 1);
      cyc(3);
      chk("step_cpu_en", 32'(cpu_en), 1);
      chk("step_done", 32'(step_done), 1);
      cyc(1);
      chk("step_halt", 32'(running), 0);
      cyc(30);
      step = 1'b0;
      cyc(10);

      // run and step rise together: run wins, step discarded.
      wait_rise();
      run = 1'b1;
      step = 1'b1;
      push(1'b0, 2);
      cyc(12);
      run = 1'b0;
      cyc(1);
      chk("simul_halt", 32'(running), 0);
      cyc(20);
      step = 1'b0;
      cyc(10);

      // Reset while in STEP: pending step dropped, measurement restarts.
      wait_rise();
      cyc(3);
      step = 1'b1;
      cyc(2);
      res = 1'b1;
      step = 1'b0;
      cyc(1);
      chk("rstep_period", 32'(period), 0);
      chk("rstep_valid", 32'(period_valid), 0);
      cyc(2);
      res = 1'b0;
      cyc(1);
      chk("rstep_running", 32'(running), 0);
      cyc(30);
      chk("remeasure_period", 32'(period), 8);
      chk("remeasure_valid", 32'(period_valid), 1);

      // Bypass run: every cycle from the second edge; drop run honours one more.
      bypass = 1'b1;
      run = 1'b1;
      push(1'b0, 10);
      cyc(1);
      chk("byp_first_edge", 32'(cpu_en), 0);
      cyc(9);
      run = 1'b0;
      cyc(1);
      chk("byp_drop_running", 32'(running), 0);
      cyc(1);
      chk("byp_stop", 32'(cpu_en), 0);
      cyc(5);

      // Bypass single step: exactly one pulse.
      step = 1'b1;
      push(1'b1, 1);
      cyc(2);
      chk("byp_step_cpu_en", 32'(cpu_en), 1);
      chk("byp_step_done", 32'(step_done), 1);
      cyc(1);
      chk("byp_step_after", 32'(cpu_en), 0);
      cyc(10);
      step = 1'b0;
      bypass = 1'b0;
      cyc(100);

      // Saturating 4-bit period with a 40-cycle tick.
      chk("sat_period", 32'(period_s), 15);
      chk("sat_valid", 32'(period_valid_s), 1);
      chk("sat_no_cpu_en", 32'(cpu_en_s), 0);
      chk("sb_drained", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_clock_step_ctrl
